// File: rtl/bfp_line_responder.sv
// bfp_line_responder: gathers bfp write bursts into line writes and splits line reads into beats
module bfp_line_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       bfp_addr_i,
  input  logic                        bfp_read_i,
  input  logic                        bfp_write_i,
  input  logic [BEAT_WIDTH-1:0]       bfp_wdata_i,
  output logic                        bfp_ready_o,
  output logic [ADDR_WIDTH-1:0]       bfp_raddr_o,
  output logic [BEAT_WIDTH-1:0]       bfp_rdata_o,
  output logic                        bfp_rvalid_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic                        mem_read_o,
  output logic                        mem_write_o,
  output logic [BEAT_WIDTH*BEATS-1:0] mem_wdata_o,
  input  logic [BEAT_WIDTH*BEATS-1:0] mem_rdata_i,
  input  logic                        mem_resp_i,
  output logic                        proto_err_o
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BEAT_WIDTH * BEATS / 8 - 1);
  typedef enum logic [2:0] {IDLE, WGATHER, MWRITE, MREAD, RESP} state_t;
  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [BEAT_WIDTH*BEATS-1:0] line_q, line_d;
  logic                        err_q, err_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // a write beat wins over a simultaneous read; the read must be re-presented
        if (bfp_write_i) begin
          addr_d                   = bfp_addr_i & ~OFF_MASK;
          line_d[BEAT_WIDTH-1:0]   = bfp_wdata_i;
          cnt_d                    = CW'(1);
          state_d                  = WGATHER;
        end else if (bfp_read_i) begin
          addr_d  = bfp_addr_i & ~OFF_MASK;
          state_d = MREAD;
        end
      end
      WGATHER: begin
        if (bfp_write_i) begin
          line_d[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] = bfp_wdata_i;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == LAST) ? MWRITE : WGATHER;
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      MWRITE: state_d = mem_resp_i ? IDLE : MWRITE;
      MREAD: begin
        if (mem_resp_i) begin
          line_d  = mem_rdata_i;
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LAST) ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bfp_ready_o  = state_q == IDLE;
  assign bfp_rvalid_o = state_q == RESP;
  assign bfp_rdata_o  = bfp_rvalid_o ? line_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] : '0;
  assign bfp_raddr_o  = bfp_rvalid_o ? addr_q : '0;
  assign mem_addr_o   = addr_q;
  assign mem_read_o   = state_q == MREAD;
  assign mem_write_o  = state_q == MWRITE;
  assign mem_wdata_o  = line_q;
  assign proto_err_o  = err_q;
endmodule
